// File: rtl/mad_inverse_seq.sv
// Inverts a multiply-add: given Y = A*B + C with known B and C, recovers
// A = (Y - C) / B and the remainder by bit-serial restoring division.
module mad_inverse_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] Y,
   input  logic [7:0] B,
   input  logic [7:0] C,
   output logic       busy,
   output logic       done,
   output logic [7:0] Q,
   output logic [7:0] R,
   output logic       div_zero,
   output logic       underflow
);

   typedef enum logic [1:0] {S_IDLE, S_SUB, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  y_q, y_d, b_q, b_d, c_q, c_d;
   logic [7:0]  dvd_q, dvd_d;
   logic [8:0]  rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        uf_q, uf_d;
   logic [7:0]  q_q, q_d, r_q, r_d;
   logic        dz_q, dz_d, ufo_q, ufo_d;

   logic [8:0]  trial;
   logic [8:0]  diff;
   logic        qbit;
   logic [7:0]  d_wrap;

   // Dividend bits shift out MSB-first while quotient bits shift in at the LSB.
   assign trial  = (rem_q << 1) | {8'd0, dvd_q[7]};
   assign diff   = trial - {1'b0, b_q};
   assign qbit   = (trial >= {1'b0, b_q});
   assign d_wrap = y_q - c_q;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      b_d     = b_q;
      c_d     = c_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      uf_d    = uf_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      ufo_d   = ufo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               y_d     = Y;
               b_d     = B;
               c_d     = C;
               state_d = S_SUB;
            end
         end
         S_SUB: begin
            dvd_d = d_wrap;
            uf_d  = (c_q > y_q);
            rem_d = 9'd0;
            cnt_d = 4'd0;
            if (b_q != 8'd0) begin
               state_d = S_DIV;
            end else begin
               q_d     = 8'hFF;
               r_d     = d_wrap;
               dz_d    = 1'b1;
               ufo_d   = (c_q > y_q);
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            rem_d = qbit ? diff : trial;
            dvd_d = {dvd_q[6:0], qbit};
            cnt_d = cnt_q + 4'd1;
            // Results are committed on the edge into DONE so they are valid with done.
            if (cnt_q == 4'd7) begin
               q_d     = {dvd_q[6:0], qbit};
               r_d     = rem_d[7:0];
               dz_d    = 1'b0;
               ufo_d   = uf_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         y_q     <= 8'd0;
         b_q     <= 8'd0;
         c_q     <= 8'd0;
         dvd_q   <= 8'd0;
         rem_q   <= 9'd0;
         cnt_q   <= 4'd0;
         uf_q    <= 1'b0;
         q_q     <= 8'd0;
         r_q     <= 8'd0;
         dz_q    <= 1'b0;
         ufo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         b_q     <= b_d;
         c_q     <= c_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         uf_q    <= uf_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         ufo_q   <= ufo_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign Q         = q_q;
   assign R         = r_q;
   assign div_zero  = dz_q;
   assign underflow = ufo_q;

endmodule
